// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and defaults for the four-way round-robin output arbiter.
// State encoding matches the legacy mux_arb_defs header (IDLE=0, GRANT=1).
package mux4_rr_arbiter_pkg;

  localparam int DEFAULT_N         = 8;
  localparam int DEFAULT_MAX_BURST = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Requester indices live on a ring of four, so increment wraps naturally.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first asserted request scanning ptr, ptr+1, ... mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] cand [4];
  logic [3:0] hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_off
    assign cand[gi] = ptr + 2'(gi);
    assign hit[gi]  = req[cand[gi]];
  end

  assign any = |req;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among four requesters,
// with bursts bounded to MAX_BURST beats per grant and one IDLE bubble per release.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_valid,
  input  logic [N-1:0] req_data0,
  input  logic [N-1:0] req_data1,
  input  logic [N-1:0] req_data2,
  input  logic [N-1:0] req_data3,
  output logic [3:0]   req_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   grant_id,
  output logic         busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    grant_id_q, grant_id_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;

  logic          pick_any;
  logic [1:0]    pick_idx;
  logic [N-1:0]  mux_out;
  logic          acc;

  rr_pick4 u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // 4:1 data mux steered by the current grant.
  always_comb begin
    mux_out = req_data0;
    case (grant_id_q)
      2'd0: mux_out = req_data0;
      2'd1: mux_out = req_data1;
      2'd2: mux_out = req_data2;
      2'd3: mux_out = req_data3;
      default: mux_out = req_data0;
    endcase
  end

  assign acc = (state_q == ST_GRANT) && req_valid[grant_id_q] && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // The output stage runs independently of the FSM so a pending beat drains across a release.
    if (acc) begin
      out_data_d  = mux_out;
      out_valid_d = 1'b1;
      beat_cnt_d  = beat_cnt_q + 1'b1;
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if ((acc && beat_cnt_q == LAST_BEAT) || !req_valid[grant_id_q]) begin
          state_d = ST_IDLE;
          ptr_d   = next_idx(grant_id_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      grant_id_q  <= 2'd0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign req_ready = acc ? (4'b0001 << grant_id_q) : 4'b0000;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed table, corner sequences, and
// randomized traffic against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_valid = 4'b0;
  logic [7:0] req_data [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0] req_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic [1:0] grant_id;
  logic       busy;

  logic [3:0] b_req_valid = 4'b0;
  logic [7:0] b_req_data = 8'h5C;
  logic [3:0] b_req_ready;
  logic       b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_grant_id;
  logic       b_busy;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.N(8), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_data0(req_data[0]), .req_data1(req_data[1]),
    .req_data2(req_data[2]), .req_data3(req_data[3]),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_id(grant_id), .busy(busy)
  );

  mux4_rr_arbiter #(.N(8), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid),
    .req_data0(b_req_data), .req_data1(b_req_data),
    .req_data2(b_req_data), .req_data3(b_req_data),
    .req_ready(b_req_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(1'b1), .grant_id(b_grant_id), .busy(b_busy)
  );

  function automatic logic [15:0] pk(input logic b, input logic [1:0] g, input logic [3:0] rr,
                                     input logic ov, input logic [7:0] od);
    return {b, g, rr, ov, od};
  endfunction

  function automatic logic [15:0] obs();
    return pk(busy, grant_id, req_ready, out_valid, out_data);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h  ({busy,gid,rdy,ov,data})", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    req_valid = 4'b0;
    b_req_valid = 4'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Behavioural reference: owner = -1 means nobody holds the channel.
  int         m_owner, m_ptr, m_gid, m_cnt;
  logic       m_ov;
  logic [7:0] m_od;

  function automatic logic m_acc();
    return (m_owner >= 0) && req_valid[m_owner] && (!m_ov || out_ready);
  endfunction

  function automatic logic [15:0] model_obs();
    logic [3:0] rr;
    rr = m_acc() ? 4'(1 << m_owner) : 4'b0;
    return pk(m_owner >= 0, 2'(m_gid), rr, m_ov, m_od);
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_gid = 0; m_cnt = 0; m_ov = 1'b0; m_od = 8'h00;
  endtask

  task automatic model_step();
    logic a;
    if (!rst_n) begin
      model_reset();
      return;
    end
    a = m_acc();
    if (a) begin
      m_od = req_data[m_owner];
      m_ov = 1'b1;
      m_cnt++;
    end else if (out_ready && m_ov) begin
      m_ov = 1'b0;
    end
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (req_valid[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_gid = m_owner;
          m_cnt = 0;
          break;
        end
      end
    end else if ((a && m_cnt == MB) || !req_valid[m_owner]) begin
      m_ptr = (m_owner + 1) % 4;
      m_owner = -1;
    end
  endtask

  typedef struct {
    logic [3:0]  rv;
    logic [7:0]  d0, d1, d3;
    logic        ordy;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic [3:0] rv, input logic [7:0] d1, input logic ordy,
                              input logic [15:0] exp);
    vec_t v;
    v.rv = rv; v.d0 = 8'h0F; v.d1 = d1; v.d3 = 8'h33; v.ordy = ordy; v.exp = exp;
    return v;
  endfunction

  initial begin
    logic [15:0] e;
    logic [7:0]  last_od;
    logic        ov_e;
    logic [3:0]  rr_e;
    int          g_e;

    // Requester 1 alone (A5, 5A, drop), then pointer follow-up and backpressure across release.
    tbl[0]  = mk(4'b0010, 8'hA5, 1'b1, pk(1'b0, 2'd0, 4'b0000, 1'b0, 8'h00));
    tbl[1]  = mk(4'b0010, 8'hA5, 1'b1, pk(1'b1, 2'd1, 4'b0010, 1'b0, 8'h00));
    tbl[2]  = mk(4'b0010, 8'h5A, 1'b1, pk(1'b1, 2'd1, 4'b0010, 1'b1, 8'hA5));
    tbl[3]  = mk(4'b0000, 8'h5A, 1'b1, pk(1'b1, 2'd1, 4'b0000, 1'b1, 8'h5A));
    tbl[4]  = mk(4'b0001, 8'h00, 1'b1, pk(1'b0, 2'd1, 4'b0000, 1'b0, 8'h5A));
    tbl[5]  = mk(4'b0001, 8'h00, 1'b1, pk(1'b1, 2'd0, 4'b0001, 1'b0, 8'h5A));
    tbl[6]  = mk(4'b0000, 8'h00, 1'b1, pk(1'b1, 2'd0, 4'b0000, 1'b1, 8'h0F));
    tbl[7]  = mk(4'b0000, 8'h00, 1'b1, pk(1'b0, 2'd0, 4'b0000, 1'b0, 8'h0F));
    tbl[8]  = mk(4'b1011, 8'h77, 1'b1, pk(1'b0, 2'd0, 4'b0000, 1'b0, 8'h0F));
    tbl[9]  = mk(4'b1011, 8'h77, 1'b1, pk(1'b1, 2'd1, 4'b0010, 1'b0, 8'h0F));
    tbl[10] = mk(4'b0000, 8'h77, 1'b0, pk(1'b1, 2'd1, 4'b0000, 1'b1, 8'h77));
    tbl[11] = mk(4'b1001, 8'h77, 1'b0, pk(1'b0, 2'd1, 4'b0000, 1'b1, 8'h77));
    tbl[12] = mk(4'b1001, 8'h77, 1'b0, pk(1'b1, 2'd3, 4'b0000, 1'b1, 8'h77));
    tbl[13] = mk(4'b1001, 8'h77, 1'b1, pk(1'b1, 2'd3, 4'b1000, 1'b1, 8'h77));
    tbl[14] = mk(4'b0000, 8'h77, 1'b1, pk(1'b1, 2'd3, 4'b0000, 1'b1, 8'h33));
    tbl[15] = mk(4'b0000, 8'h77, 1'b1, pk(1'b0, 2'd3, 4'b0000, 1'b0, 8'h33));

    reset_all();
    @(negedge clk);
    check("reset_state", obs(), pk(1'b0, 2'd0, 4'b0000, 1'b0, 8'h00));
    check("reset_state_b1", {8'h00, b_busy, b_grant_id, b_req_ready, b_out_valid},
          {8'h00, 1'b0, 2'd0, 4'b0000, 1'b0});
    next_cycle();

    reset_all();
    req_data[2] = 8'h22;
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].rv;
      req_data[0] = tbl[i].d0;
      req_data[1] = tbl[i].d1;
      req_data[3] = tbl[i].d3;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("table_row%0d", i), obs(), tbl[i].exp);
      next_cycle();
    end

    // All four requesters, bursts of MB with one bubble between grants.
    reset_all();
    for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    last_od = 8'h00;
    ov_e = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c % 5 == 0) begin
        rr_e = 4'b0;
        g_e = (c == 0) ? 0 : ((c - 1) / 5) % 4;
      end else begin
        g_e = (c / 5) % 4;
        rr_e = 4'(1 << g_e);
      end
      @(negedge clk);
      check($sformatf("rr_all4_c%0d", c), obs(), pk(c % 5 != 0, 2'(g_e), rr_e, ov_e, last_od));
      if (rr_e != 4'b0) begin
        last_od = 8'h10 + 8'(g_e);
        ov_e = 1'b1;
      end else begin
        ov_e = 1'b0;
      end
      next_cycle();
    end

    // Backpressure: output stalls three cycles, then the next beat lands the cycle ready returns.
    reset_all();
    req_valid = 4'b0001;
    req_data[0] = 8'hA1;
    out_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    check("bp_first_accept", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b0, 8'h00));
    next_cycle();
    req_data[0] = 8'hB2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_stall%0d", c), obs(), pk(1'b1, 2'd0, 4'b0000, 1'b1, 8'hA1));
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_same_cycle", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b1, 8'hA1));
    next_cycle();
    @(negedge clk);
    check("bp_next_beat", obs(), pk(1'b1, 2'd0, 4'b0001, 1'b1, 8'hB2));
    next_cycle();

    // Reset in the middle of a burst from requester 2 with a beat held in the output.
    reset_all();
    req_valid = 4'b0100;
    req_data[2] = 8'hC3;
    out_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("midburst_pre", obs(), pk(1'b1, 2'd2, 4'b0000, 1'b1, 8'hC3));
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("midburst_after_reset", obs(), pk(1'b0, 2'd0, 4'b0000, 1'b0, 8'h00));
    next_cycle();

    // Idle: no requests for ten cycles.
    reset_all();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("idle_c%0d", c), obs(), pk(1'b0, 2'd0, 4'b0000, 1'b0, 8'h00));
      next_cycle();
    end

    // MAX_BURST=1 instance: requesters 1 and 3 alternate, one beat per grant.
    reset_all();
    b_req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      g_e = (c == 0) ? 0 : ((((c - 1) / 2) % 2) == 0 ? 1 : 3);
      rr_e = (c % 2 == 1) ? 4'(1 << g_e) : 4'b0;
      @(negedge clk);
      check($sformatf("burst1_c%0d", c), {9'h000, b_busy, b_grant_id, b_req_ready},
            {9'h000, 1'(c % 2), 2'(g_e), rr_e});
      next_cycle();
    end
    b_req_valid = 4'b0;

    // Randomized traffic against the reference model.
    reset_all();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) req_data[i] = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e = model_obs();
      check($sformatf("rand_c%0d", c), obs(), e);
      model_step();
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
